// File: rtl/vend_sequencer.sv
// Back-end sequencer for the vending machine: runs the dispense motor for the sold item,
// then pays change as dime and nickel strobes (dimes first). Owns the sticky motor fault.
module vend_sequencer #(
    parameter int unsigned MOTOR_TIMEOUT = 1000,
    parameter int unsigned PULSE_LEN     = 4,
    parameter int unsigned GAP_LEN       = 4,
    parameter int unsigned CNT_W         = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vend_req,
    input  logic [3:0] vend_item,
    input  logic [7:0] vend_change,
    input  logic       motor_done,
    input  logic       fault_clr,
    output logic [3:0] motor_en,
    output logic       dime_pulse,
    output logic       nickel_pulse,
    output logic       vend_busy,
    output logic       vend_done,
    output logic       req_err,
    output logic       fault
);

    typedef enum logic [2:0] {
        StIdle, StMotor, StDimeHi, StDimeLo, StNickHi, StNickLo, StDone
    } state_e;

    localparam logic [CNT_W-1:0] MotorLast = CNT_W'(MOTOR_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PulseLast = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GapLast   = CNT_W'(GAP_LEN - 1);

    state_e           state_q;
    logic [CNT_W-1:0] timer_q;
    logic [1:0]       dime_cnt_q;
    logic             nick_cnt_q;

    logic   item_ok;
    logic   change_ok;
    logic   req_ok;
    state_e pay_state;

    // First payout step given the coins still owed.
    function automatic state_e payout_next(input logic [1:0] dimes, input logic nicks);
        state_e nxt;
        if (dimes != 2'd0) begin
            nxt = StDimeHi;
        end else if (nicks) begin
            nxt = StNickHi;
        end else begin
            nxt = StDone;
        end
        return nxt;
    endfunction

    always_comb begin
        item_ok   = vend_item inside {4'b0001, 4'b0010, 4'b0100, 4'b1000};
        change_ok = vend_change inside {8'h00, 8'h05, 8'h10, 8'h15, 8'h20};
        req_ok    = item_ok && change_ok && !fault;
        // The dime count is decremented on leaving the gap, so look one coin ahead there.
        case (state_q)
            StDimeLo: pay_state = payout_next(dime_cnt_q - 2'd1, nick_cnt_q);
            StNickLo: pay_state = StDone;
            default:  pay_state = payout_next(dime_cnt_q, nick_cnt_q);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            dime_cnt_q   <= '0;
            nick_cnt_q   <= 1'b0;
            motor_en     <= '0;
            dime_pulse   <= 1'b0;
            nickel_pulse <= 1'b0;
            vend_busy    <= 1'b0;
            vend_done    <= 1'b0;
            req_err      <= 1'b0;
            fault        <= 1'b0;
        end else begin
            vend_done <= 1'b0;
            req_err   <= 1'b0;
            // A timeout set later in this block overrides a coincident clear.
            if (fault_clr) begin
                fault <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (vend_req) begin
                        if (req_ok) begin
                            motor_en   <= vend_item;
                            dime_cnt_q <= vend_change[5:4];
                            nick_cnt_q <= (vend_change[3:0] == 4'h5);
                            timer_q    <= '0;
                            vend_busy  <= 1'b1;
                            state_q    <= StMotor;
                        end else begin
                            req_err <= 1'b1;
                        end
                    end
                end
                StMotor: begin
                    if (motor_done || (timer_q == MotorLast)) begin
                        if (!motor_done) begin
                            fault <= 1'b1;
                        end
                        motor_en     <= '0;
                        timer_q      <= '0;
                        state_q      <= pay_state;
                        dime_pulse   <= (pay_state == StDimeHi);
                        nickel_pulse <= (pay_state == StNickHi);
                        vend_done    <= (pay_state == StDone);
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StDimeHi: begin
                    if (timer_q == PulseLast) begin
                        dime_pulse <= 1'b0;
                        timer_q    <= '0;
                        state_q    <= StDimeLo;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StDimeLo: begin
                    if (timer_q == GapLast) begin
                        dime_cnt_q   <= dime_cnt_q - 2'd1;
                        timer_q      <= '0;
                        state_q      <= pay_state;
                        dime_pulse   <= (pay_state == StDimeHi);
                        nickel_pulse <= (pay_state == StNickHi);
                        vend_done    <= (pay_state == StDone);
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StNickHi: begin
                    if (timer_q == PulseLast) begin
                        nickel_pulse <= 1'b0;
                        timer_q      <= '0;
                        state_q      <= StNickLo;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StNickLo: begin
                    if (timer_q == GapLast) begin
                        nick_cnt_q <= 1'b0;
                        timer_q    <= '0;
                        state_q    <= pay_state;
                        vend_done  <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StDone: begin
                    vend_busy <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// Randomized bench for vend_sequencer: each request's full output trace is predicted from
// the sale rules (motor time, 8 cycles per coin, one done cycle) and compared every cycle.
module tb_vend_sequencer;

    localparam int unsigned TO = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       vend_req;
    logic [3:0] vend_item;
    logic [7:0] vend_change;
    logic       motor_done;
    logic       fault_clr;
    logic [3:0] motor_en;
    logic       dime_pulse;
    logic       nickel_pulse;
    logic       vend_busy;
    logic       vend_done;
    logic       req_err;
    logic       fault;

    logic [9:0] obs;
    int         total = 0;
    int         bad = 0;
    bit         model_fault = 1'b0;

    vend_sequencer #(
        .MOTOR_TIMEOUT(TO),
        .PULSE_LEN    (4),
        .GAP_LEN      (4),
        .CNT_W        (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vend_req    (vend_req),
        .vend_item   (vend_item),
        .vend_change (vend_change),
        .motor_done  (motor_done),
        .fault_clr   (fault_clr),
        .motor_en    (motor_en),
        .dime_pulse  (dime_pulse),
        .nickel_pulse(nickel_pulse),
        .vend_busy   (vend_busy),
        .vend_done   (vend_done),
        .req_err     (req_err),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    assign obs = {motor_en, dime_pulse, nickel_pulse, vend_busy, vend_done, req_err, fault};

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b (motor_en,dime,nick,busy,done,err,fault)",
                     tag, got, exp);
        end
    endtask

    function automatic logic [9:0] pack(input logic [3:0] me, input bit dp, input bit np,
                                        input bit bz, input bit dn, input bit er, input bit f);
        return {me, dp, np, bz, dn, er, f};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // d: edge (counted from acceptance) at which motor_done is first sampled high.
    task automatic request(input logic [3:0] item, input logic [7:0] change, input int d,
                           input bit noisy, input bit clr_at_to);
        bit ok;
        bit to;
        int nd;
        int nn;
        int m;
        int len;
        ok = ($countones(item) == 1) && (change inside {8'h00, 8'h05, 8'h10, 8'h15, 8'h20})
             && !model_fault;
        vend_req    = 1'b1;
        vend_item   = item;
        vend_change = change;
        motor_done  = 1'b0;
        fault_clr   = 1'b0;
        tick();
        vend_req = 1'b0;
        if (!ok) begin
            check($sformatf("reject i=%b c=%h", item, change), obs,
                  pack(4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, model_fault));
            tick();
            check("reject_after", obs, pack(4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_fault));
            return;
        end
        nd  = int'(change[7:4]);
        nn  = (change[3:0] == 4'h5) ? 1 : 0;
        to  = (d > int'(TO));
        m   = to ? int'(TO) : d;
        len = m + 8 * (nd + nn) + 1;
        for (int t = 0; t <= len; t++) begin
            logic [3:0] me;
            bit dp;
            bit np;
            bit bz;
            bit dn;
            bit f;
            int u;
            me = 4'b0;
            dp = 1'b0;
            np = 1'b0;
            bz = (t < len);
            dn = 1'b0;
            f  = to && (t >= m);
            if (t < m) begin
                me = item;
            end else if (t < len) begin
                u = t - m;
                if (u < 8 * nd) begin
                    dp = ((u % 8) < 4);
                end else begin
                    u = u - 8 * nd;
                    if (u < 8 * nn) np = ((u % 8) < 4);
                    else dn = 1'b1;
                end
            end
            check($sformatf("txn i=%b c=%h d=%0d t=%0d", item, change, d, t), obs,
                  pack(me, dp, np, bz, dn, 1'b0, f));
            if (t < len) begin
                motor_done  = (t + 1 >= d);
                fault_clr   = clr_at_to && to && (t + 1 == m);
                vend_req    = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
                vend_item   = 4'($urandom);
                vend_change = 8'($urandom);
                tick();
            end
        end
        vend_req    = 1'b0;
        motor_done  = 1'b0;
        fault_clr   = 1'b0;
        model_fault = to;
    endtask

    task automatic clear_fault();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("fault_clr", obs, '0);
        model_fault = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [7:0] chg_tab [8];
        chg_tab = '{8'h00, 8'h05, 8'h10, 8'h15, 8'h20, 8'h12, 8'h25, 8'h30};
        reset       = 1'b0;
        vend_req    = 1'b0;
        vend_item   = 4'b0;
        vend_change = 8'h00;
        motor_done  = 1'b0;
        fault_clr   = 1'b0;
        tick();
        check("reset_state", obs, '0);
        reset = 1'b1;
        tick();

        // Async reset in the middle of MOTOR.
        vend_req    = 1'b1;
        vend_item   = 4'b0010;
        vend_change = 8'h10;
        tick();
        vend_req = 1'b0;
        check("mid_motor", obs, pack(4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        tick();
        #2 reset = 1'b0;
        #1 check("async_reset", obs, '0);
        #1 reset = 1'b1;
        tick();

        request(4'b0100, 8'h15, 10, 1'b0, 1'b0);
        request(4'b0001, 8'h20, 7, 1'b0, 1'b0);
        request(4'b1000, 8'h00, 3, 1'b0, 1'b0);
        request(4'b0011, 8'h15, 5, 1'b0, 1'b0);
        request(4'b0100, 8'h12, 5, 1'b0, 1'b0);
        request(4'b0001, 8'h25, 5, 1'b0, 1'b0);
        request(4'b0000, 8'h05, 5, 1'b0, 1'b0);
        // Timeout, then rejection while faulted, then clear and retry.
        request(4'b0010, 8'h05, 30, 1'b0, 1'b0);
        request(4'b0001, 8'h00, 2, 1'b0, 1'b0);
        clear_fault();
        request(4'b0001, 8'h10, 4, 1'b1, 1'b0);
        // motor_done on the timeout cycle wins; then the first faulting edge.
        request(4'b1000, 8'h10, int'(TO), 1'b1, 1'b0);
        request(4'b0100, 8'h00, int'(TO) + 1, 1'b0, 1'b0);
        clear_fault();
        // Clear coinciding with the timeout leaves the fault set.
        request(4'b0010, 8'h15, 40, 1'b0, 1'b1);
        clear_fault();

        for (int n = 0; n < 60; n++) begin
            logic [3:0] item;
            int gap;
            if (model_fault && ($urandom_range(0, 1) == 1)) clear_fault();
            item = ($urandom_range(0, 3) != 0) ? (4'b0001 << $urandom_range(0, 3))
                                               : 4'($urandom);
            request(item, chg_tab[$urandom_range(0, 7)], int'($urandom_range(1, 24)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                tick();
                check("idle_gap", obs, pack(4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_fault));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
